gxor_serial_ctrl: RTL and testbench



---
 rtl/gxor_serial_ctrl.sv | 117 +++++++++++
 tb/tb_gxor_serial_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gxor_serial_ctrl.sv
// Bit-serial XOR sequencer: streams two captured operands LSB-first through one
// shared gxor gate and assembles the result word and its parity.

module gxor (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module gxor_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIDTH-1:0]           op_a,
  input  logic [WIDTH-1:0]           op_b,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       parity,
  output logic [$clog2(WIDTH):0]     bit_idx
);
  localparam int IW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_result;
  logic             r_par;
  logic [IW-1:0]    r_bit_idx;
  logic             r_busy;
  logic             r_done;
  logic             w_y;
  logic [WIDTH-1:0] w_y_msb;

  gxor u_gxor (
    .a (r_sa[0]),
    .b (r_sb[0]),
    .y (w_y)
  );

  // Gate output enters at the MSB so that after WIDTH shifts bit i lands at position i.
  assign w_y_msb = WIDTH'(w_y) << (WIDTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sa      <= '0;
      r_sb      <= '0;
      r_result  <= '0;
      r_par     <= 1'b0;
      r_bit_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sa      <= op_a;
            r_sb      <= op_b;
            r_result  <= '0;
            r_par     <= 1'b0;
            r_bit_idx <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_result  <= '0;
            r_par     <= 1'b0;
            r_bit_idx <= '0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_result  <= (r_result >> 1) | w_y_msb;
            r_par     <= r_par ^ w_y;
            r_sa      <= r_sa >> 1;
            r_sb      <= r_sb >> 1;
            r_bit_idx <= r_bit_idx + IW'(1);
            if (r_bit_idx == IW'(WIDTH - 1)) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign parity  = r_par;
  assign bit_idx = r_bit_idx;
endmodule

// File: tb/tb_gxor_serial_ctrl.sv
// Directed bench for gxor_serial_ctrl: a transaction-level model checked every
// cycle, a result scoreboard popped on done, and literal spot checks.

module tb_gxor_serial_ctrl;
  localparam int W  = 8;
  localparam int IW = $clog2(W) + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          parity;
  logic [IW-1:0] bit_idx;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [W-1:0] exp_q[$];

  gxor_serial_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .parity  (parity),
    .bit_idx (bit_idx)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 running with k bits processed, 2 done cycle.
  int         m_phase;
  int         m_k;
  logic [W-1:0] m_x;
  logic [W-1:0] m_res;
  logic       m_par;

  function automatic logic [W-1:0] low_bits_on_top(input logic [W-1:0] x, input int k);
    if (k == 0) return '0;
    return x << (W - k);
  endfunction

  function automatic logic parity_low(input logic [W-1:0] x, input int k);
    logic [31:0] mask;
    mask = (32'd1 << k) - 32'd1;
    return ^(32'(x) & mask);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_x = '0; m_res = '0; m_par = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_x = op_a ^ op_b; m_k = 0; m_res = '0; m_par = 1'b0; m_phase = 1;
           end
        1: if (abort) begin
             m_res = '0; m_par = 1'b0; m_phase = 0;
           end else begin
             m_k = m_k + 1;
             m_res = low_bits_on_top(m_x, m_k);
             m_par = parity_low(m_x, m_k);
             if (m_k == W) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle compare plus scoreboard on done
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("done", 32'(done), 32'(m_phase == 2));
      check("result", 32'(result), 32'(m_res));
      check("parity", 32'(parity), 32'(m_par));
      if (m_phase != 0) check("bit_idx", 32'(bit_idx), 32'(m_k));
      if (done) begin
        if (exp_q.size() == 0) check("sb_unexpected_done", 32'd1, 32'd0);
        else check("sb_result", 32'(result), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drivers
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int done_cyc);
    start = 1'b1; op_a = a; op_b = b;
    exp_q.push_back(a ^ b);
    @(posedge clk); #2;
    start = 1'b0;
    done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done && done_cyc == 0) done_cyc = c;
      if (done_cyc != 0 && !busy) break;
    end
  endtask

  task automatic wait_bit_idx(input int idx, output logic hit);
    hit = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy && bit_idx == IW'(idx)) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_bit_idx", 32'(hit), 32'd1);
  endtask

  initial begin
    int   lat;
    int   n_done;
    logic hit;
    start = 1'b0; abort = 1'b0; op_a = '0; op_b = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_parity", 32'(parity), 32'd0);
    chk_en = 1'b1;
    #10 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 32'(busy), 32'd0);

    // Basic op
    run_op(8'hA5, 8'h3C, lat);
    check("basic_latency", 32'(lat), 32'(W + 1));
    check("basic_result", 32'(result), 32'h99);
    check("basic_parity", 32'(parity), 32'd0);
    repeat (3) @(negedge clk);
    check("basic_hold", 32'(result), 32'h99);

    // Parity corners
    run_op(8'h01, 8'h00, lat);
    check("odd_result", 32'(result), 32'h01);
    check("odd_parity", 32'(parity), 32'd1);
    run_op(8'hFF, 8'hFF, lat);
    check("ff_result", 32'(result), 32'h00);
    check("ff_parity", 32'(parity), 32'd0);

    // Start while busy is ignored
    @(posedge clk); #2;
    start = 1'b1; op_a = 8'h12; op_b = 8'h34;
    exp_q.push_back(8'h26);
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op_a = 8'hC0; op_b = 8'h0C;
    @(posedge clk); #2;
    start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        check("busy_start_result", 32'(result), 32'h26);
      end
    end
    check("busy_start_ndone", 32'(n_done), 32'd1);

    // Abort at bit_idx 4
    @(posedge clk); #2;
    start = 1'b1; op_a = 8'hAA; op_b = 8'h55;
    @(posedge clk); #2;
    start = 1'b0;
    wait_bit_idx(4, hit);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_parity", 32'(parity), 32'd0);
    run_op(8'hF0, 8'h0F, lat);
    check("post_abort_result", 32'(result), 32'hFF);
    check("post_abort_parity", 32'(parity), 32'd0);
    check("post_abort_latency", 32'(lat), 32'(W + 1));

    // Async reset during RUN at bit_idx 5
    @(posedge clk); #2;
    start = 1'b1; op_a = 8'h3C; op_b = 8'h77;
    @(posedge clk); #2;
    start = 1'b0;
    wait_bit_idx(5, hit);
    #2 rst_n = 1'b0;
    #1;
    check("rrst_busy", 32'(busy), 32'd0);
    check("rrst_done", 32'(done), 32'd0);
    check("rrst_result", 32'(result), 32'd0);
    check("rrst_parity", 32'(parity), 32'd0);
    check("rrst_bit_idx", 32'(bit_idx), 32'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back ops, each started in the first idle cycle
    run_op(8'h5A, 8'h0F, lat);
    check("b2b1_result", 32'(result), 32'h55);
    check("b2b1_parity", 32'(parity), 32'd0);
    run_op(8'h81, 8'h02, lat);
    check("b2b2_result", 32'(result), 32'h83);
    check("b2b2_parity", 32'(parity), 32'd1);
    check("b2b2_latency", 32'(lat), 32'(W + 1));

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
